// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between the adder result bus, the frame accumulator and the result sink.
// The master side is the upstream producer plus the sink; the slave side is the accumulator.
interface adder_sum_accumulator_if #(
  parameter int IN_W  = 9,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in_sum;
  logic             in_ready;
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_data;
  logic             acc_ovf;
  logic [7:0]       sample_cnt;

  modport master (
    output in_valid, in_sum, acc_ready,
    input  in_ready, acc_valid, acc_data, acc_ovf, sample_cnt
  );

  modport slave (
    input  in_valid, in_sum, acc_ready,
    output in_ready, acc_valid, acc_data, acc_ovf, sample_cnt
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Sums FRAME_LEN adder results per frame and offers the total on a valid/ready output.
// Define ACC_SATURATE_EN to clamp the total on overflow instead of wrapping it.
module adder_sum_accumulator #(
  parameter int IN_W      = 9,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  adder_sum_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0]       LAST_CNT = 8'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             acc_valid_q, acc_valid_d;

  logic             accept_s;
  logic [ACC_W:0]   sum_ext_s;
  logic             ovf_now_s;

  assign accept_s  = bus.in_valid && (state_q == ST_ACCUM);
  // One extra bit catches the carry out of the accumulator.
  assign sum_ext_s = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_sum};
  assign ovf_now_s = sum_ext_s[ACC_W];

  // State register and all datapath/output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  // Next-state logic; clear wins over every handshake.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_ACCUM;
          else        state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          if (accept_s && (cnt_q == LAST_CNT)) state_d = ST_HOLD;
          else                                 state_d = ST_ACCUM;
        end
        ST_HOLD: begin
          if (bus.acc_ready) state_d = ST_ACCUM;
          else               state_d = ST_HOLD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Accumulator, overflow flag and sample count.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = {ACC_W{1'b0}};
      ovf_d = 1'b0;
      cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          acc_d = {ACC_W{1'b0}};
          ovf_d = 1'b0;
          cnt_d = 8'd0;
        end
        ST_ACCUM: begin
          if (accept_s) begin
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | ovf_now_s;
`ifdef ACC_SATURATE_EN
            // Once clamped, any further non-zero sum overflows again and stays clamped.
            acc_d = ovf_now_s ? ACC_MAX : sum_ext_s[ACC_W-1:0];
`else
            acc_d = sum_ext_s[ACC_W-1:0];
`endif
          end else begin
            acc_d = acc_q;
          end
        end
        ST_HOLD: begin
          if (bus.acc_ready) begin
            acc_d = {ACC_W{1'b0}};
            ovf_d = 1'b0;
            cnt_d = 8'd0;
          end else begin
            acc_d = acc_q;
          end
        end
        default: begin
          acc_d = {ACC_W{1'b0}};
          ovf_d = 1'b0;
          cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    in_ready_d  = 1'b0;
    acc_valid_d = 1'b0;
    case (state_d)
      ST_ACCUM: in_ready_d  = 1'b1;
      ST_HOLD:  acc_valid_d = 1'b1;
      default: begin
        in_ready_d  = 1'b0;
        acc_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.acc_data   = acc_q;
  assign bus.acc_ovf    = ovf_q;
  assign bus.sample_cnt = cnt_q;

endmodule
